mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's registered 2**SEL_WIDTH:1 bit mux among 2**SEL_WIDTH requesters. Each requester raises a request; the arbiter grants one at a time for bounded bursts and drives the mux select. It forwards the selected data bit with a valid flag. It sits between the requesting sources and the shared mux datapath, and replaces static select wiring.

---
 rtl/mux_arb_pkg.sv | 29 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// default sizing constants and the one-hot encode helper.
package mux_arb_pkg;

  localparam int SEL_WIDTH_DEF = 2;
  localparam int BURST_LEN_DEF = 4;
  localparam int N_DEF         = 2 ** SEL_WIDTH_DEF;

  // Widest requester count the one-hot helper supports (SEL_WIDTH <= 6).
  localparam int MAX_W = 6;
  localparam int MAX_N = 2 ** MAX_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int cnt_width(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

  localparam int CNT_W_DEF = cnt_width(BURST_LEN_DEF);

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_W-1:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotated-priority search: first set request bit at ptr, ptr+1, ... with
// modulo-N wrap. Purely combinational.
module rr_pick #(
  parameter  int SEL_WIDTH = 2,
  localparam int N         = 2 ** SEL_WIDTH
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] pick,
  output logic                 any
);

  logic [SEL_WIDTH-1:0] idx;

  always_comb begin
    pick = ptr;
    any  = 1'b0;
    idx  = ptr;
    for (int i = 0; i < N; i++) begin
      // N is a power of two, so the add wraps modulo N by itself.
      idx = ptr + SEL_WIDTH'(i);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared registered N:1 bit mux,
// with bounded bursts and zero-gap handoff between requesters.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int N         = 2 ** SEL_WIDTH,
  localparam int CNT_W     = cnt_width(BURST_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         arb_REQ,
  input  logic [N-1:0]         arb_IN,
  output logic [N-1:0]         arb_GNT,
  output logic [SEL_WIDTH-1:0] arb_SEL,
  output logic                 arb_OUT,
  output logic                 arb_VALID,
  output logic                 dbg_state
);

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic                 out_q, out_d;
  logic                 valid_q, valid_d;

  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic [MAX_N-1:0]     pick_oh_full;
  logic [N-1:0]         pick_oh;
  logic                 release_c;

  // In GRANT the search starts just past the current owner, which is the
  // pointer value a release would store; in IDLE the stored pointer is used.
  assign pick_ptr = (state_q == ST_GRANT) ? sel_q + SEL_WIDTH'(1) : ptr_q;

  rr_pick #(.SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req  (arb_REQ),
    .ptr  (pick_ptr),
    .pick (pick_idx),
    .any  (pick_any)
  );

  assign pick_oh_full = onehot(MAX_W'(pick_idx));
  assign pick_oh      = pick_oh_full[N-1:0];
  assign release_c    = !arb_REQ[sel_q] || (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = pick_oh;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!release_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            sel_d = pick_idx;
            gnt_d = pick_oh;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_d   = arb_IN[sel_q];
    valid_d = (state_q == ST_GRANT) && arb_REQ[sel_q];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign arb_GNT   = gnt_q;
  assign arb_SEL   = sel_q;
  assign arb_OUT   = out_q;
  assign arb_VALID = valid_q;
  assign dbg_state = state_q[0];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a behavioural model predicts every
// registered output; a monitor compares after each rising edge.
module tb_mux_rr_arbiter;

  localparam int SEL_WIDTH = 2;
  localparam int BURST_LEN = 4;
  localparam int N         = 2 ** SEL_WIDTH;
  localparam int W         = N + SEL_WIDTH + 3;

  // ---------------- clock / reset ----------------
  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [N-1:0]         arb_REQ = '0;
  logic [N-1:0]         arb_IN  = '0;
  logic [N-1:0]         arb_GNT;
  logic [SEL_WIDTH-1:0] arb_SEL;
  logic                 arb_OUT;
  logic                 arb_VALID;
  logic                 dbg_state;

  always #5 CLK = ~CLK;

  mux_rr_arbiter #(.SEL_WIDTH(SEL_WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .arb_REQ   (arb_REQ),
    .arb_IN    (arb_IN),
    .arb_GNT   (arb_GNT),
    .arb_SEL   (arb_SEL),
    .arb_OUT   (arb_OUT),
    .arb_VALID (arb_VALID),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  bit m_busy;
  int m_ptr, m_cnt, m_sel;
  bit m_out, m_valid;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic int pick_from(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [N-1:0]         g;
    logic [SEL_WIDTH-1:0] s;
    g = '0;
    if (m_busy) g[m_sel] = 1'b1;
    s = m_sel[SEL_WIDTH-1:0];
    return {g, s, m_out, m_valid, m_busy};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_out = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] din);
    bit nout, nvalid;
    int p;
    nout   = din[m_sel];
    nvalid = m_busy && req[m_sel];
    if (!m_busy) begin
      p = pick_from(req, m_ptr);
      if (p >= 0) begin
        m_busy = 1; m_sel = p; m_cnt = 0;
      end
    end else if (req[m_sel] && m_cnt < BURST_LEN - 1) begin
      m_cnt++;
    end else begin
      m_ptr = (m_sel + 1) % N;
      p = pick_from(req, m_ptr);
      if (p >= 0) begin
        m_sel = p; m_cnt = 0;
      end else begin
        m_busy = 0;
      end
    end
    m_out   = nout;
    m_valid = nvalid;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got gnt/sel/out/valid/state=%b required %b", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic [N-1:0] req, input logic [N-1:0] din);
    @(negedge CLK);
    arb_REQ = req;
    arb_IN  = din;
    if (!rst && RST) begin
      RST = 1'b0;
      #1;
      check("async_reset", {arb_GNT, arb_SEL, arb_OUT, arb_VALID, dbg_state}, '0);
    end
    RST = rst;
    if (!rst) model_reset();
    else      model_step(req, din);
    exp_q.push_back(model_vec());
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {arb_GNT, arb_SEL, arb_OUT, arb_VALID, dbg_state}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int left;
    model_reset();
    repeat (2) cycle(1'b0, '0, '0);

    // mid-burst reset, then restart from pointer 0
    repeat (3) cycle(1'b1, 4'b0100, 4'b0100);
    cycle(1'b0, 4'b0011, 4'b0011);
    repeat (6) cycle(1'b1, 4'b0011, 4'b0001);

    // single persistent requester
    cycle(1'b0, '0, '0);
    repeat (12) cycle(1'b1, 4'b0100, 4'b0100);

    // full contention
    cycle(1'b0, '0, '0);
    repeat (22) cycle(1'b1, 4'b1111, 4'($urandom_range(0, 15)));

    // early release to 3, then pointer wrap back to 0
    cycle(1'b0, '0, '0);
    repeat (3) cycle(1'b1, 4'b0001, 4'b1001);
    repeat (3) cycle(1'b1, 4'b1000, 4'b1001);
    repeat (10) cycle(1'b1, 4'b1001, 4'b1001);

    // data steering
    cycle(1'b0, '0, '0);
    repeat (10) cycle(1'b1, 4'b1010, 4'b1010);
    repeat (10) cycle(1'b1, 4'b1010, 4'b0101);
    repeat (3) cycle(1'b1, 4'b0000, 4'b1111);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) r = '0;
      cycle(($urandom_range(0, 59) != 0), r, 4'($urandom_range(0, 15)));
    end
    repeat (3) cycle(1'b1, '0, '0);

    left = 40;
    while (exp_q.size() > 0 && left > 0) begin
      @(posedge CLK);
      left--;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
